load_store_unit: RTL and testbench

Initiator-side memory access unit between the sequential core's execute stage and the 64-bit-word data memory. It accepts one load or store request at a time and drives the memory's word-addressed port, which has an asynchronous read and a synchronous write. Loads use byte-lane extraction with sign or zero extension. Sub-doubleword stores use read-modify-write. Misaligned and illegal requests are reported as a fault without touching memory.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-addressed 64-bit memory with
// asynchronous read and synchronous write. Sub-doubleword stores use a
// read-modify-write sequence; misaligned or illegal requests fault without
// touching memory.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | reading the addressed word (load result or store merge base)
// WRITE  | committing the store word
// RESP   | one-cycle completion pulse
module load_store_unit #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_store_data,
    output logic              resp_valid,
    output logic [63:0]       resp_load_data,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [63:0]       mem_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [2:0]         funct3_q;
    logic               is_store_q;
    logic [63:0]        sdata_q;
    logic [63:0]        rdata_q;
    logic               req_fault;
    logic               accept;

    // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
    function automatic logic [63:0] load_extract(input logic [63:0] word,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  f3);
        logic [63:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{56{s[7]}},  s[7:0]};
            3'b001:  return {{48{s[15]}}, s[15:0]};
            3'b010:  return {{32{s[31]}}, s[31:0]};
            3'b011:  return s;
            3'b100:  return {56'd0, s[7:0]};
            3'b101:  return {48'd0, s[15:0]};
            3'b110:  return {32'd0, s[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    // Replace bytes off..off+size-1 of the read word with the low store bytes.
    function automatic logic [63:0] store_merge(input logic [63:0] word,
                                                input logic [63:0] sdata,
                                                input logic [2:0]  off,
                                                input logic [1:0]  size);
        logic [63:0] m;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return (word & ~(m << {off, 3'b000})) | ((sdata & m) << {off, 3'b000});
    endfunction

    // Fault decode on the incoming request: illegal size code or misalignment.
    always_comb begin
        req_fault = 1'b0;
        if (req_funct3 == 3'b111)
            req_fault = 1'b1;
        else if (req_is_store && req_funct3[2])
            req_fault = 1'b1;
        else begin
            case (req_funct3[1:0])
                2'b01:   req_fault = req_addr[0];
                2'b10:   req_fault = |req_addr[1:0];
                2'b11:   req_fault = |req_addr[2:0];
                default: req_fault = 1'b0;
            endcase
        end
    end

    assign accept = (state_q == S_IDLE) && req_valid;

    // State register, request capture and registered response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            funct3_q       <= '0;
            is_store_q     <= 1'b0;
            sdata_q        <= '0;
            rdata_q        <= '0;
            resp_load_data <= '0;
            resp_fault     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= req_addr;
                funct3_q   <= req_funct3;
                is_store_q <= req_is_store;
                sdata_q    <= req_store_data;
                if (req_fault) begin
                    resp_load_data <= '0;
                    resp_fault     <= 1'b1;
                end
            end
            if (state_q == S_ACCESS) begin
                rdata_q <= mem_read_data;
                if (!is_store_q) begin
                    resp_load_data <= load_extract(mem_read_data, addr_q[2:0], funct3_q);
                    resp_fault     <= 1'b0;
                end
            end
            if (state_q == S_WRITE) begin
                resp_load_data <= '0;
                resp_fault     <= 1'b0;
            end
        end
    end

    // Next-state logic and memory-side outputs; strobes are gated by reset so
    // a reset during WRITE never commits.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = !reset;
                if (req_valid) begin
                    if (req_fault)
                        state_d = S_RESP;
                    else if (req_is_store && req_funct3[1:0] == 2'b11)
                        state_d = S_WRITE;
                    else
                        state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_read = !reset;
                mem_addr = {addr_q[ADDR_W-1:3], 3'b000};
                state_d  = is_store_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                mem_write = !reset;
                mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
                if (funct3_q[1:0] == 2'b11)
                    mem_write_data = sdata_q;
                else
                    mem_write_data = store_merge(rdata_q, sdata_q, addr_q[2:0], funct3_q[1:0]);
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard: the driver pushes
// expected responses and expected memory writes, a monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = '0;
    logic [63:0] req_store_data = '0;
    logic        resp_valid;
    logic [63:0] resp_load_data;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic [63:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_read_data;

    load_store_unit #(.ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_load_data(resp_load_data),
        .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: asynchronous read, write on the clock edge.
    logic [63:0] mem [0:15];
    logic [3:0]  idx;
    logic        preload = 1'b1;
    assign idx = mem_addr[6:3];
    assign mem_read_data = mem[idx];
    always @(posedge clk) begin
        if (preload)
            mem[2] <= 64'h8877665544332211;
        else if (mem_write)
            mem[idx] <= mem_write_data;
    end

    typedef struct {
        string       name;
        logic [63:0] data;
        logic        fault;
        bit          chk_data;
        int          acc;
        int          lat;
        int          rd0;
        int          wr0;
        int          reads;
        int          writes;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wexp_t;

    exp_t  sb[$];
    wexp_t wq[$];
    int    cyc = 0;
    int    rd_cnt = 0;
    int    wr_cnt = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT responds or writes memory.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
                    check({e.name, "_fault"}, {63'd0, resp_fault}, {63'd0, e.fault});
                    if (e.chk_data)
                        check({e.name, "_data"}, resp_load_data, e.data);
                    check({e.name, "_reads"}, 64'(rd_cnt - e.rd0), 64'(e.reads));
                    check({e.name, "_writes"}, 64'(wr_cnt - e.wr0), 64'(e.writes));
                end
            end
            if (mem_write) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    check("write_addr", mem_addr, w.addr);
                    check("write_data", mem_write_data, w.data);
                end
                wr_cnt++;
            end else begin
                check("idle_write_data", mem_write_data, 64'd0);
            end
            if (mem_read)
                rd_cnt++;
            if (!mem_read && !mem_write)
                check("idle_mem_addr", mem_addr, 64'd0);
        end
    end

    // Wait for the unit to be idle, present one request, return just after
    // the accept edge.
    task automatic issue(input string name, input bit st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input bit push_resp, input logic [63:0] exp_data,
                         input logic exp_fault, input bit chk_data, input int lat,
                         input int reads, input int writes,
                         input bit push_wr, input logic [63:0] exp_wdata);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_addr       = addr;
        req_store_data = sdata;
        e.name = name; e.data = exp_data; e.fault = exp_fault; e.chk_data = chk_data;
        e.acc = cyc; e.lat = lat; e.rd0 = rd_cnt; e.wr0 = wr_cnt;
        e.reads = reads; e.writes = writes;
        if (push_resp) sb.push_back(e);
        if (push_wr) wq.push_back('{addr: {addr[63:3], 3'b000}, data: exp_wdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_resp_queue", 64'(sb.size()), 64'd0);
        check("drain_write_queue", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        int wr_snap;
        repeat (3) @(negedge clk);
        check("reset_req_ready", {63'd0, req_ready}, 64'd0);
        check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset_resp_data", resp_load_data, 64'd0);
        check("reset_resp_fault", {63'd0, resp_fault}, 64'd0);
        check("reset_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check("reset_mem_addr", mem_addr, 64'd0);
        preload = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {63'd0, req_ready}, 64'd1);

        // Loads from word 0x10 = 0x8877665544332211
        issue("lb_13",  0, 3'b000, 64'h13, 0, 1, 64'h0000000000000044, 0, 1, 2, 1, 0, 0, 0);
        issue("lb_17",  0, 3'b000, 64'h17, 0, 1, 64'hFFFFFFFFFFFFFF88, 0, 1, 2, 1, 0, 0, 0);
        issue("lhu_16", 0, 3'b101, 64'h16, 0, 1, 64'h0000000000008877, 0, 1, 2, 1, 0, 0, 0);
        issue("lh_16",  0, 3'b001, 64'h16, 0, 1, 64'hFFFFFFFFFFFF8877, 0, 1, 2, 1, 0, 0, 0);
        issue("lw_14",  0, 3'b010, 64'h14, 0, 1, 64'hFFFFFFFF88776655, 0, 1, 2, 1, 0, 0, 0);
        issue("lwu_14", 0, 3'b110, 64'h14, 0, 1, 64'h0000000088776655, 0, 1, 2, 1, 0, 0, 0);
        issue("lbu_11", 0, 3'b100, 64'h11, 0, 1, 64'h0000000000000022, 0, 1, 2, 1, 0, 0, 0);
        issue("ld_10",  0, 3'b011, 64'h10, 0, 1, 64'h8877665544332211, 0, 1, 2, 1, 0, 0, 0);

        // Faults: no memory activity, response at T+1 with zero data
        issue("lw_12_fault",  0, 3'b010, 64'h12, 0, 1, 64'd0, 1, 1, 1, 0, 0, 0, 0);
        issue("sbu_fault",    1, 3'b100, 64'h10, 64'h55, 1, 64'd0, 1, 1, 1, 0, 0, 0, 0);
        issue("f3_111_fault", 0, 3'b111, 64'h10, 0, 1, 64'd0, 1, 1, 1, 0, 0, 0, 0);
        issue("sh_11_fault",  1, 3'b001, 64'h11, 64'hBEEF, 1, 64'd0, 1, 1, 1, 0, 0, 0, 0);
        issue("ld_14_fault",  0, 3'b011, 64'h14, 0, 1, 64'd0, 1, 1, 1, 0, 0, 0, 0);
        drain();

        // SH interrupted by reset during its WRITE cycle
        wr_snap = wr_cnt;
        issue("sh_reset", 1, 3'b001, 64'h10, 64'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("sh_reset_ready", {63'd0, req_ready}, 64'd1);
        check("sh_reset_mem", mem[2], 64'h8877665544332211);
        check("sh_reset_no_write", 64'(wr_cnt - wr_snap), 64'd0);
        repeat (2) @(negedge clk);

        // Partial store via read-modify-write, then read back
        issue("sb_11", 1, 3'b000, 64'h11, 64'hFFFFFFFFFFFFFFAB, 1, 0, 0, 0, 3, 1, 1,
              1, 64'h887766554433AB11);
        issue("ld_after_sb", 0, 3'b011, 64'h10, 0, 1, 64'h887766554433AB11, 0, 1, 2, 1, 0, 0, 0);
        issue("sd_10", 1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 1, 0, 0, 0, 2, 0, 1,
              1, 64'h0123456789ABCDEF);
        issue("ld_after_sd", 0, 3'b011, 64'h10, 0, 1, 64'h0123456789ABCDEF, 0, 1, 2, 1, 0, 0, 0);
        issue("sw_14", 1, 3'b010, 64'h14, 64'h00000000DEADBEEF, 1, 0, 0, 0, 3, 1, 1,
              1, 64'hDEADBEEF89ABCDEF);
        issue("ld_after_sw", 0, 3'b011, 64'h10, 0, 1, 64'hDEADBEEF89ABCDEF, 0, 1, 2, 1, 0, 0, 0);
        issue("sh_12", 1, 3'b001, 64'h12, 64'h1234, 1, 0, 0, 0, 3, 1, 1,
              1, 64'hDEADBEEF1234CDEF);
        issue("lh_after_sh", 0, 3'b001, 64'h12, 0, 1, 64'h0000000000001234, 0, 1, 2, 1, 0, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
